// File: rtl/mod_n_serial_detector.sv
// Serial divisibility detector: running residue of a bit stream modulo MODULUS.
// Bit order is MSB-first by default; define LSB_FIRST_EN for LSB-first with a weight register.
module mod_n_serial_detector #(
    parameter int MODULUS = 3,
    parameter int RES_W   = $clog2(MODULUS),
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             bit_valid,
    input  logic             Bit,
    input  logic             frame_start,
    output logic             out,
    output logic             out_valid,
    output logic [RES_W-1:0] residue,
    output logic [CNT_W-1:0] bit_count
);

    localparam logic [RES_W:0]   MOD_V   = (RES_W+1)'(MODULUS);
    localparam logic [RES_W-1:0] ONE     = RES_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [RES_W-1:0] residue_q, residue_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             out_q, out_d;
    logic             vld_q, vld_d;

    // Single compare-subtract; callers guarantee t < 2*MODULUS.
    function automatic logic [RES_W-1:0] reduce(input logic [RES_W:0] t);
        logic [RES_W:0] r;
        r = (t >= MOD_V) ? t - MOD_V : t;
        return r[RES_W-1:0];
    endfunction

    function automatic logic legal(input logic [RES_W-1:0] r);
        return ({1'b0, r} < MOD_V);
    endfunction

`ifdef LSB_FIRST_EN
    logic [RES_W-1:0] w_q, w_d;

    function automatic logic [RES_W-1:0] add_mod(input logic [RES_W-1:0] a,
                                                 input logic [RES_W-1:0] b);
        return reduce({1'b0, a} + {1'b0, b});
    endfunction
`endif

    always_comb begin
        residue_d = residue_q;
        cnt_d     = cnt_q;
        out_d     = out_q;
        vld_d     = 1'b0;
`ifdef LSB_FIRST_EN
        w_d       = w_q;
`endif
        if (frame_start) begin
            if (bit_valid) begin
                residue_d = RES_W'(Bit);
                cnt_d     = CNT_ONE;
                vld_d     = 1'b1;
`ifdef LSB_FIRST_EN
                w_d       = add_mod(ONE, ONE);
`endif
            end else begin
                residue_d = '0;
                cnt_d     = '0;
`ifdef LSB_FIRST_EN
                w_d       = ONE;
`endif
            end
            out_d = (residue_d == '0);
        end else if (bit_valid) begin
            vld_d = 1'b1;
            cnt_d = (&cnt_q) ? cnt_q : cnt_q + CNT_ONE;
`ifdef LSB_FIRST_EN
            if (!legal(residue_q)) begin
                residue_d = '0;
            end else if (Bit) begin
                residue_d = add_mod(residue_q, legal(w_q) ? w_q : ONE);
            end
            w_d = legal(w_q) ? add_mod(w_q, w_q) : ONE;
`else
            // Upset-recovery: an out-of-range residue restarts from zero.
            if (!legal(residue_q)) begin
                residue_d = '0;
            end else begin
                residue_d = reduce({residue_q, Bit});
            end
`endif
            out_d = (residue_d == '0);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            residue_q <= '0;
            cnt_q     <= '0;
            out_q     <= 1'b1;
            vld_q     <= 1'b0;
`ifdef LSB_FIRST_EN
            w_q       <= ONE;
`endif
        end else begin
            residue_q <= residue_d;
            cnt_q     <= cnt_d;
            out_q     <= out_d;
            vld_q     <= vld_d;
`ifdef LSB_FIRST_EN
            w_q       <= w_d;
`endif
        end
    end

    assign residue   = residue_q;
    assign bit_count = cnt_q;
    assign out       = out_q;
    assign out_valid = vld_q;

endmodule

// File: doc/mod_n_serial_detector.md
Name: mod_n_serial_detector

Overview:
- Serial divisibility detector for a configurable modulus MODULUS.
- Consumes one bit per qualified clock and keeps the running residue of the bit stream received so far.
- Flags whether the accumulated value is a multiple of MODULUS.
- Adds over the fixed mod-3 detector: a valid qualifier, frame restart, residue/count visibility and an output-valid strobe.
- Sits between a serial receiver and a checker or control FSM.

Parameters:
- MODULUS, 3, divisor; legal range 2..255.
- RES_W, $clog2(MODULUS), residue register width (derived; do not override).
- CNT_W, 16, width of the accepted-bit counter.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- bit_valid  input  1  Bit is accepted on this edge when high
- Bit  input  1  serial data bit, MSB-first by default
- frame_start  input  1  restart accumulation at this edge
- out  output  1  registered; 1 when current residue == 0
- out_valid  output  1  one-cycle strobe, high the cycle after an accepted bit
- residue  output  RES_W  current residue, 0..MODULUS-1
- bit_count  output  CNT_W  bits accepted in the current frame, saturating

Behaviour:
- Reset: asynchronous, active-high; one clock domain only.
  - Reset values: residue=0, out=1, out_valid=0, bit_count=0, all internal state cleared.
  - Reset is effective immediately and mid-frame; the next accepted bit starts a new frame.
- Update rule (MSB-first) on an edge with bit_valid=1 and frame_start=0:
  - t = 2*residue + Bit, evaluated at RES_W+1 bits; t < 2*MODULUS always holds.
  - residue <= (t >= MODULUS) ? t - MODULUS : t. Single compare-subtract, no divider.
  - out <= (new residue == 0).
  - out_valid <= 1.
  - bit_count <= bit_count+1, saturating at all-ones.
- frame_start=1 with bit_valid=1: the bit is the first bit of a new frame.
  - residue <= Bit mod MODULUS, i.e. Bit.
  - bit_count <= 1; out <= (Bit==0); out_valid <= 1.
- frame_start=1 with bit_valid=0:
  - residue <= 0, out <= 1, bit_count <= 0, out_valid <= 0.
- bit_valid=0 and frame_start=0: all state holds; out_valid <= 0.
- Latency: out and residue reflect an accepted bit on the following edge, one cycle after acceptance.
- An empty frame (no bits accepted) reads as divisible: out=1.
- residue is never outside 0..MODULUS-1. Any illegal value reached by an upset is forced to 0 on the next accepted bit (default branch); out then follows.
- Throughput: one bit per clock with no stall; back-to-back bit_valid is legal.

Optional Feature:
- Macro LSB_FIRST_EN.
- Defined: bit order is LSB-first.
  - An internal weight register w (RES_W bits) is reset/frame_start to 1 mod MODULUS.
  - Per accepted bit: residue <= (residue + Bit*w) mod MODULUS, by compare-subtract.
  - w <= (2*w) mod MODULUS.
  - frame_start with bit_valid uses w=1 for that bit, then advances w to 2 mod MODULUS.
  - w reaching 0 for even MODULUS is legal; subsequent bits then do not change the residue.
- Undefined: MSB-first only; no weight register is instantiated. Port list is identical in both builds.

Test Plan:
- Reset then no bits, MODULUS=3: out=1, residue=0, bit_count=0, out_valid=0 indefinitely.
- MODULUS=3, MSB-first stream 1,1,0,0 (12) with bit_valid each cycle: residue sequence 1,0,0,0; out sequence 0,1,1,1; out_valid high 4 cycles; bit_count=4.
- MODULUS=5, stream 1,1,0,1 (13): residues 1,3,1,3; out=0; then frame_start+Bit=1, followed by Bit=0,1 (5): residue 0, out=1, bit_count=3.
- MODULUS=3, bits 1,0 accepted (residue=2), then reset asserted mid-cycle between edges: outputs go to reset values immediately. Next bit 1 gives residue=1, bit_count=1.
- CNT_W=4, MODULUS=7: 20 consecutive accepted 0 bits give bit_count saturated at 15, out=1. Gaps with bit_valid=0 hold residue and drop out_valid.
- LSB_FIRST_EN, MODULUS=3, bits 0,0,1,1 LSB-first (12): residues 0,0,1,0; final out=1. With bits 1,0,1 (5): final residue=2, out=0.
